// File: rtl/io_pkg.sv
// Shared run-length nibble definitions for the io encoder/decoder pair.
package io_pkg;

  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned NIBBLES_PER_WORD = 8;
  localparam int unsigned WORD_W           = NIBBLE_W * NIBBLES_PER_WORD;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned RUN_W            = 3;
  localparam logic [NIBBLE_W-1:0] RUN_PAD  = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_EMIT,
    ST_FLUSH
  } io_state_e;

  typedef struct packed {
    logic             value;
    logic [RUN_W-1:0] run;
  } nibble_t;

endpackage

// File: rtl/io_nibble_packer.sv
// Collects nibbles into a 32-bit word, oldest nibble ending up in bits 31:28.
module io_nibble_packer
  import io_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  nibble_t           nib,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (push) begin
      word  <= {word[WORD_W-NIBBLE_W-1:0], nib};
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_rle_encoder.sv
// Run-length encodes a stream of variable-width fields into packed 4-bit {value, run} nibbles.
module io_rle_encoder
  import io_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned MAX_RUN = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic [4:0]      in_width,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int unsigned LEN_W = 5;

  io_state_e          state;
  io_state_e          ret_state;
  logic [IN_W-1:0]    sreg;
  logic [LEN_W-1:0]   bits_left;
  logic               last_q;
  logic               run_val;
  logic [RUN_W-1:0]   run_cnt;

  logic               pk_clear;
  logic               pk_push;
  nibble_t            pk_nib;
  logic [WORD_W-1:0]  pk_word;
  logic [CNT_W-1:0]   pk_count;

  logic               cur_bit_c;
  logic               run_open_c;
  logic               extend_c;
  logic               close_c;
  logic               word_full_c;
  logic               field_done_c;
  logic [LEN_W-1:0]   eff_width_c;
  nibble_t            open_nib_c;
  io_state_e          shift_next_c;

  // Run decisions for the bit at the head of the shift register.
  always_comb begin
    cur_bit_c    = sreg[IN_W-1];
    run_open_c   = (run_cnt != '0);
    extend_c     = run_open_c && (cur_bit_c == run_val) && (run_cnt < RUN_W'(MAX_RUN));
    close_c      = run_open_c && !extend_c;
    word_full_c  = (pk_count == CNT_W'(NIBBLES_PER_WORD - 1));
    field_done_c = (bits_left == LEN_W'(1));
    eff_width_c  = (in_width > LEN_W'(IN_W)) ? LEN_W'(IN_W) : in_width;
    open_nib_c   = '{value: run_val, run: run_cnt};
    shift_next_c = ST_SHIFT;
    if (field_done_c) begin
      shift_next_c = last_q ? ST_FLUSH : ST_IDLE;
    end
  end

  // Packer control: closed runs while shifting, then closing run and padding while flushing.
  always_comb begin
    pk_push  = 1'b0;
    pk_clear = 1'b0;
    pk_nib   = open_nib_c;
    case (state)
      ST_SHIFT: pk_push = close_c;
      ST_FLUSH: begin
        if (run_open_c) begin
          pk_push = 1'b1;
        end else if (pk_count != CNT_W'(NIBBLES_PER_WORD)) begin
          pk_push = 1'b1;
          pk_nib  = nibble_t'(RUN_PAD);
        end
      end
      ST_EMIT:  pk_clear = out_ready;
      default:  ;
    endcase
  end

  io_nibble_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (pk_clear),
    .push  (pk_push),
    .nib   (pk_nib),
    .word  (pk_word),
    .count (pk_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      sreg      <= '0;
      bits_left <= '0;
      last_q    <= 1'b0;
      run_val   <= 1'b0;
      run_cnt   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (in_valid && in_ready) begin
            // Left-align the field so the head bit is always sreg[IN_W-1].
            sreg      <= IN_W'(in_data << (LEN_W'(IN_W) - eff_width_c));
            bits_left <= eff_width_c;
            last_q    <= in_last;
            if (eff_width_c != '0) begin
              state    <= ST_SHIFT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else if (in_last) begin
              state    <= ST_FLUSH;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          sreg      <= sreg << 1;
          bits_left <= bits_left - LEN_W'(1);
          if (extend_c) begin
            run_cnt <= run_cnt + RUN_W'(1);
          end else begin
            run_val <= cur_bit_c;
            run_cnt <= RUN_W'(1);
          end
          if (close_c && word_full_c) begin
            state     <= ST_EMIT;
            ret_state <= shift_next_c;
            out_valid <= 1'b1;
            out_data  <= {pk_word[WORD_W-NIBBLE_W-1:0], open_nib_c};
            out_last  <= 1'b0;
          end else begin
            state <= shift_next_c;
            if (shift_next_c == ST_IDLE) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        ST_FLUSH: begin
          if (run_open_c) begin
            run_cnt <= '0;
          end else if (pk_count == CNT_W'(NIBBLES_PER_WORD)) begin
            state     <= ST_EMIT;
            ret_state <= ST_IDLE;
            out_valid <= 1'b1;
            out_data  <= pk_word;
            out_last  <= 1'b1;
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= ret_state;
            if (ret_state == ST_IDLE) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_rle_encoder.md
IO_RLE_ENCODER -- requirements
Module: io_rle_encoder

Interface
REQ-001 SHALL have parameter IN_W, default 16: maximum field width in bits.
REQ-002 SHALL have parameter MAX_RUN, default 7: longest run carried by one nibble.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: a field is presented.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a field this cycle.
REQ-007 SHALL have port in_data, input, IN_W: field bits, right-aligned.
REQ-008 SHALL have port in_width, input, 5: field width 0..IN_W; values above IN_W are treated as IN_W.
REQ-009 SHALL have port in_last, input, 1: final field of the message.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a complete encoded word.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the word.
REQ-012 SHALL have port out_data, output, 32: encoded word.
REQ-013 SHALL have port out_last, output, 1: final word of the message.
REQ-014 SHALL have port busy, output, 1: high when not IDLE.

Function
REQ-015 SHALL encode a continuous bit stream into 4-bit nibbles {value, run[2:0]}, run 1..MAX_RUN.
REQ-016 SHALL use run 0 (nibble 4'h0) as padding only.
REQ-017 SHALL pack 8 nibbles per word, filling bits 31:28 first.
REQ-018 SHALL serialize each field MSB first, starting at bit in_width-1.
REQ-019 SHALL process one bit per cycle.
REQ-020 SHALL provide states IDLE, SHIFT, EMIT, FLUSH.
REQ-021 In IDLE, in_ready SHALL be 1; a handshake (in_valid & in_ready) latches data, width and last, then moves to SHIFT, or directly to FLUSH when width is 0.
REQ-022 In SHIFT, each cycle SHALL extend the open run when the bit equals the current value and run < MAX_RUN; otherwise it closes the open run into the pack register and opens a new run of 1.
REQ-023 Runs SHALL continue across field boundaries; a field boundary never closes a run by itself.
REQ-024 When the pack register holds 8 nibbles, the block SHALL enter EMIT and assert out_valid, with shifting stalled.
REQ-025 out_data and out_last SHALL be held stable while out_valid & !out_ready.
REQ-026 On the out handshake, the block SHALL clear the pack register and return to its prior activity (SHIFT, FLUSH or IDLE).
REQ-027 After the last bit of a field: if last, go to FLUSH; else go to IDLE, with in_ready asserted the next cycle (latency: one field every width+1 cycles, absent stalls).
REQ-028 In FLUSH, the block SHALL close the open run (if any), pad the remaining nibbles with 4'h0, and emit the word with out_last=1.
REQ-029 If the pack register is empty and no run is open, FLUSH SHALL emit nothing and assert out_last on the most recent word still pending; if no word is pending, it emits 32'h0 with out_last=1.
REQ-030 A run closing when the pack register already holds 7 nibbles SHALL fill the word exactly; under FLUSH that word carries out_last=1 and no pad word follows.
REQ-031 in_ready SHALL be 0 in SHIFT, EMIT and FLUSH; out_valid SHALL be 1 only in EMIT.

Reset
REQ-032 rst_n low SHALL immediately force IDLE and drive out_valid=0, out_last=0, out_data=0, in_ready=0 (in_ready returns to 1 on the first clock after release), busy=0.
REQ-033 rst_n low SHALL clear the run counter, nibble count and pack register; any partial word is discarded.

Structure
REQ-034 A shared package io_pkg SHALL hold the state enum, NIBBLE_W=4, NIBBLES_PER_WORD=8 and the RUN_PAD=0 constant, for reuse by the decoder.
REQ-035 The nibble packer (8x4 shift register plus count) SHALL be one sub-module, io_nibble_packer.

Verification
REQ-036 Field 16'hFFFF, width 16, last -> one word 32'hFFA00000, out_last=1.
REQ-037 Field 6'b000101, width 6, last -> 32'h39190000, out_last=1.
REQ-038 Field 16'hAAAA, width 16, last -> 32'h91919191 then 32'h91919191, out_last only on the second, no pad word.
REQ-039 Fields 8'hFF (width 8) then 8'hFF (width 8, last) -> run spans both: 32'hFFA00000 (16 ones = 7+7+2).
REQ-040 out_ready held low 5 cycles during EMIT -> out_data stable, in_ready=0, no bit lost; word accepted on the release cycle.
REQ-041 rst_n pulsed low mid-SHIFT -> outputs zero asynchronously; the next message encodes with no residue from the old one.
